// File: rtl/snn_spi_pkg.sv
// snn_spi_pkg: shared types and constants for the SNN SPI configuration link
package snn_spi_pkg;
  localparam int SPI_FRAME_BITS = 8;
  typedef enum logic [2:0] {IDLE, SCLK_LO, SCLK_HI, HOLD, TRAIL, GAP} spi_state_t;
  typedef enum logic [7:0] {
    OP_NOP       = 8'h00,
    OP_WR_WEIGHT = 8'h01,
    OP_WR_DELAY  = 8'h02,
    OP_WR_THRESH = 8'h03,
    OP_RD_STATUS = 8'h80
  } snn_opcode_t;
endpackage

// File: rtl/spi_config_master_if.sv
// spi_config_master_if: byte stream handshake and SPI pins of spi_config_master
interface spi_config_master_if
  import snn_spi_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS
);
  logic [FRAME_BITS-1:0] tx_data, rx_data;
  logic tx_valid, tx_last, tx_ready, rx_valid, busy, SCLK, MOSI, SS, MISO;
  modport master (
    input  tx_data, tx_valid, tx_last, MISO,
    output tx_ready, rx_data, rx_valid, busy, SCLK, MOSI, SS
  );
  modport slave (
    output tx_data, tx_valid, tx_last, MISO,
    input  tx_ready, rx_data, rx_valid, busy, SCLK, MOSI, SS
  );
endinterface

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: counts CLK_DIV cycles per SCLK phase, ticks on the last one
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic system_clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == '0;
  always_ff @(posedge system_clock)
    if (reset || restart || tick) cnt <= RELOAD;
    else if (enable) cnt <= cnt - W'(1);
endmodule

// File: rtl/spi_config_master.sv
// spi_config_master: mode-0 MSB-first SPI master streaming bytes with SS held across bursts
module spi_config_master
  import snn_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = SPI_FRAME_BITS
) (
  input logic system_clock,
  input logic reset,
  spi_config_master_if.master bus
);
  localparam int BW = $clog2(FRAME_BITS);
  spi_state_t state, state_d;
  logic sclk, sclk_d, mosi, mosi_d, ss, ss_d, last, last_d;
  logic tx_ready, rx_valid, rx_valid_d, busy;
  logic [FRAME_BITS-1:0] tx_sr, tx_sr_d, rx_sr, rx_sr_d, rx_data, rx_data_d;
  logic [BW-1:0] bitcnt, bitcnt_d;
  logic accept, tick, enable;
  assign accept = bus.tx_valid && tx_ready;
  assign enable = state inside {SCLK_LO, SCLK_HI, TRAIL, GAP};
  spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .system_clock(system_clock),
    .reset(reset),
    .restart(accept),
    .enable(enable),
    .tick(tick)
  );
  always_comb begin
    state_d = state;
    sclk_d = sclk;
    mosi_d = mosi;
    ss_d = ss;
    last_d = last;
    tx_sr_d = tx_sr;
    rx_sr_d = rx_sr;
    rx_data_d = rx_data;
    bitcnt_d = bitcnt;
    rx_valid_d = 1'b0;
    case (state)
      IDLE, HOLD: if (accept) begin
        tx_sr_d = bus.tx_data;
        last_d = bus.tx_last;
        bitcnt_d = '0;
        ss_d = 1'b0;
        mosi_d = bus.tx_data[FRAME_BITS-1];
        state_d = SCLK_LO;
      end
      SCLK_LO: if (tick) begin
        sclk_d = 1'b1;
        state_d = SCLK_HI;
      end
      SCLK_HI: if (tick) begin
        sclk_d = 1'b0;
        rx_sr_d = {rx_sr[FRAME_BITS-2:0], bus.MISO};
        if (bitcnt != BW'(FRAME_BITS - 1)) begin
          tx_sr_d = tx_sr << 1;
          mosi_d = tx_sr[FRAME_BITS-2];
          bitcnt_d = bitcnt + BW'(1);
          state_d = SCLK_LO;
        end else begin
          rx_data_d = rx_sr_d;
          rx_valid_d = 1'b1;
          state_d = last ? TRAIL : HOLD;
        end
      end
      TRAIL: if (tick) begin
        ss_d = 1'b1;
        mosi_d = 1'b0;
        state_d = GAP;
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // tx_ready/busy follow the next state so every output stays a plain flop
  always_ff @(posedge system_clock)
    if (reset) begin
      state <= IDLE;
      sclk <= 1'b0;
      mosi <= 1'b0;
      ss <= 1'b1;
      last <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      bitcnt <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      sclk <= sclk_d;
      mosi <= mosi_d;
      ss <= ss_d;
      last <= last_d;
      tx_sr <= tx_sr_d;
      rx_sr <= rx_sr_d;
      rx_data <= rx_data_d;
      bitcnt <= bitcnt_d;
      rx_valid <= rx_valid_d;
      tx_ready <= state_d inside {IDLE, HOLD};
      busy <= state_d != IDLE;
    end
  assign bus.SCLK = sclk;
  assign bus.MOSI = mosi;
  assign bus.SS = ss;
  assign bus.tx_ready = tx_ready;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data = rx_data;
  assign bus.busy = busy;
endmodule

// File: tb/tb_spi_config_master.sv
// tb_spi_config_master: directed checks of spi_config_master at CLK_DIV=4 and CLK_DIV=1
module tb_spi_config_master;
  logic system_clock = 1'b0;
  logic reset = 1'b1;
  always #5 system_clock = ~system_clock;

  spi_config_master_if #(.FRAME_BITS(8)) a ();
  spi_config_master_if #(.FRAME_BITS(8)) c ();
  spi_config_master #(.CLK_DIV(4), .FRAME_BITS(8)) dut_a (.system_clock(system_clock), .reset(reset), .bus(a.master));
  spi_config_master #(.CLK_DIV(1), .FRAME_BITS(8)) dut_c (.system_clock(system_clock), .reset(reset), .bus(c.master));

  logic loop_a = 1'b1, miso_a = 1'b0;
  assign a.MISO = loop_a ? a.MOSI : miso_a;
  assign c.MISO = c.MOSI;

  int checks = 0, failures = 0;
  int cyc = 0;
  int e_acc = 0;
  always @(posedge system_clock) cyc <= cyc + 1;

  int rises = 0, ss_rises = 0, rxvs = 0;
  logic [31:0] mosi_log = '0;
  logic [23:0] rx_hist = '0;
  logic sclk_p = 1'b0, ss_p = 1'b1, mosi_p = 1'b0, hi_change = 1'b0;
  always @(negedge system_clock) begin
    if (a.SCLK && !sclk_p) begin
      rises <= rises + 1;
      mosi_log <= {mosi_log[30:0], a.MOSI};
    end
    if (a.SCLK && sclk_p && a.MOSI !== mosi_p) hi_change <= 1'b1;
    if (a.SS && !ss_p) ss_rises <= ss_rises + 1;
    if (a.rx_valid) begin
      rxvs <= rxvs + 1;
      rx_hist <= {rx_hist[15:0], a.rx_data};
    end
    sclk_p <= a.SCLK;
    ss_p <= a.SS;
    mosi_p <= a.MOSI;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic l);
    int n = 0;
    a.tx_data = d;
    a.tx_last = l;
    a.tx_valid = 1'b1;
    while (a.tx_ready !== 1'b1 && n < 200) begin
      @(negedge system_clock);
      n++;
    end
    chk("accept_timeout", 32'(n < 200), 1);
    @(posedge system_clock);
    @(negedge system_clock);
    e_acc = cyc;
    a.tx_valid = 1'b0;
  endtask

  task automatic at_t(input int n);
    while (cyc < e_acc + n - 1) @(negedge system_clock);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (!(a.tx_ready === 1'b1 && a.busy === 1'b0) && n < 500) begin
      @(negedge system_clock);
      n++;
    end
    chk("idle_timeout", 32'(n < 500), 1);
    @(negedge system_clock);
  endtask

  initial begin
    int r0, x0, s0, n, k;
    logic bad, prev;
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, x0, s0, n, k;
    logic bad, prev;
    a.tx_valid = 1'b0; a.tx_data = '0; a.tx_last = 1'b0;
    c.tx_valid = 1'b0; c.tx_data = '0; c.tx_last = 1'b0;
    repeat (2) @(negedge system_clock);
    chk("rst_ss", a.SS, 1);
    chk("rst_sclk", a.SCLK, 0);
    chk("rst_mosi", a.MOSI, 0);
    chk("rst_tx_ready", a.tx_ready, 0);
    chk("rst_rx_valid", a.rx_valid, 0);
    chk("rst_rx_data", a.rx_data, 0);
    chk("rst_busy", a.busy, 0);
    reset = 1'b0;
    @(negedge system_clock);
    chk("idle_tx_ready", a.tx_ready, 1);
    chk("idle_busy", a.busy, 0);

    // single byte 0xA5 loopback
    r0 = rises; x0 = rxvs; s0 = ss_rises;
    send_a(8'hA5, 1'b1);
    chk("t1_ss_low", a.SS, 0);
    chk("t1_mosi_msb", a.MOSI, 1);
    chk("t1_ready_low", a.tx_ready, 0);
    chk("t1_busy", a.busy, 1);
    at_t(4);  chk("t4_sclk_low", a.SCLK, 0);
    at_t(5);  chk("t5_sclk_high", a.SCLK, 1);
    at_t(64); chk("t64_no_rxv", a.rx_valid, 0);
    at_t(65); chk("t65_rxv", a.rx_valid, 1);
    chk("t65_rx_data", a.rx_data, 8'hA5);
    at_t(66); chk("t66_rxv_pulse", a.rx_valid, 0);
    at_t(68); chk("t68_ss_low", a.SS, 0);
    at_t(69); chk("t69_ss_high", a.SS, 1);
    at_t(72); chk("t72_not_ready", a.tx_ready, 0);
    at_t(73); chk("t73_ready", a.tx_ready, 1);
    chk("t73_busy", a.busy, 0);
    @(negedge system_clock);
    chk("single_rises", rises - r0, 8);
    chk("single_mosi_bits", mosi_log[7:0], 8'hA5);
    chk("single_rxv_count", rxvs - x0, 1);
    chk("single_ss_rise", ss_rises - s0, 1);

    // burst of three bytes with SS held low
    r0 = rises; x0 = rxvs; s0 = ss_rises;
    send_a(8'h01, 1'b0);
    send_a(8'h80, 1'b0);
    send_a(8'hFF, 1'b1);
    wait_idle_a();
    chk("burst_rises", rises - r0, 24);
    chk("burst_ss_rises", ss_rises - s0, 1);
    chk("burst_rxv_count", rxvs - x0, 3);
    chk("burst_rx_bytes", rx_hist, 24'h0180FF);
    chk("burst_mosi_bits", mosi_log[23:0], 24'h0180FF);

    // MISO tied high then low
    loop_a = 1'b0; miso_a = 1'b1;
    send_a(8'h00, 1'b1);
    wait_idle_a();
    chk("miso1_rx", a.rx_data, 8'hFF);
    miso_a = 1'b0;
    send_a(8'hFF, 1'b1);
    wait_idle_a();
    chk("miso0_rx", a.rx_data, 8'h00);
    loop_a = 1'b1;

    // tx_valid held high with changing data through the whole frame
    r0 = rises; x0 = rxvs;
    a.tx_data = 8'h5A; a.tx_last = 1'b1; a.tx_valid = 1'b1;
    n = 0;
    while (a.tx_ready !== 1'b1 && n < 200) begin @(negedge system_clock); n++; end
    chk("held_accept_timeout", 32'(n < 200), 1);
    @(posedge system_clock);
    @(negedge system_clock);
    e_acc = cyc;
    bad = 1'b0;
    for (int i = 1; i <= 72; i++) begin
      if (a.tx_ready !== 1'b0) bad = 1'b1;
      a.tx_data = a.tx_data + 8'h11;
      a.tx_last = ~a.tx_last;
      if (i < 72) @(negedge system_clock);
    end
    a.tx_valid = 1'b0;
    chk("held_ready_low", bad, 0);
    wait_idle_a();
    repeat (4) @(negedge system_clock);
    chk("held_rises", rises - r0, 8);
    chk("held_rx_data", a.rx_data, 8'h5A);
    chk("held_rxv_count", rxvs - x0, 1);
    chk("held_mosi_bits", mosi_log[7:0], 8'h5A);
    chk("mosi_stable_while_high", hi_change, 0);

    // reset on the third rising SCLK
    send_a(8'hE7, 1'b1);
    n = 0; k = 0; prev = a.SCLK;
    while (n < 3 && k < 200) begin
      @(negedge system_clock);
      if (a.SCLK && !prev) n++;
      prev = a.SCLK;
      k++;
    end
    chk("rise3_timeout", 32'(n), 3);
    chk("rise3_mosi_high", a.MOSI, 1);
    reset = 1'b1;
    x0 = rxvs;
    @(negedge system_clock);
    reset = 1'b0;
    chk("mid_rst_ss", a.SS, 1);
    chk("mid_rst_sclk", a.SCLK, 0);
    chk("mid_rst_mosi", a.MOSI, 0);
    chk("mid_rst_busy", a.busy, 0);
    chk("mid_rst_rxv", a.rx_valid, 0);
    chk("mid_rst_ready", a.tx_ready, 0);
    repeat (80) @(negedge system_clock);
    chk("mid_rst_no_rxv", rxvs - x0, 0);
    chk("mid_rst_idle_ready", a.tx_ready, 1);
    send_a(8'h3C, 1'b1);
    at_t(65);
    chk("post_rst_rxv", a.rx_valid, 1);
    chk("post_rst_rx_data", a.rx_data, 8'h3C);
    wait_idle_a();

    // CLK_DIV=1 instance, loopback 0x3C
    c.tx_data = 8'h3C; c.tx_last = 1'b1; c.tx_valid = 1'b1;
    n = 0;
    while (c.tx_ready !== 1'b1 && n < 200) begin @(negedge system_clock); n++; end
    chk("div1_accept_timeout", 32'(n < 200), 1);
    @(posedge system_clock);
    @(negedge system_clock);
    e_acc = cyc;
    c.tx_valid = 1'b0;
    bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (c.SS !== 1'b0 || c.SCLK !== 1'(i % 2 == 0) || c.rx_valid !== 1'b0) bad = 1'b1;
      @(negedge system_clock);
    end
    chk("div1_sclk_ss_pattern", bad, 0);
    chk("div1_t17_rxv", c.rx_valid, 1);
    chk("div1_t17_rx_data", c.rx_data, 8'h3C);
    chk("div1_t17_ss_low", c.SS, 0);
    @(negedge system_clock);
    chk("div1_t18_ss_high", c.SS, 1);
    chk("div1_t18_rxv_pulse", c.rx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
